// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: FSM states and forwarding select codes.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // A write to r0 is architecturally discarded, so it can never be a producer.
   function automatic logic regHit(input logic [4:0] rw, input logic regWr, input logic [4:0] rx);
      return regWr && (rw != 5'd0) && (rw == rx);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: EX/ID register fields in, stall/flush/forward controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

   logic [4:0]       idRa;
   logic [4:0]       idRb;
   logic [4:0]       exRa;
   logic [4:0]       exRb;
   logic [4:0]       exRw;
   logic             exRegWr;
   logic             exMemtoReg;
   logic             exBrTaken;
   logic             exJump;
   logic             hazard;
   logic             pcHold;
   logic             ifidHold;
   logic             ifidFlush;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   modport master (
      output idRa, idRb, exRa, exRb, exRw, exRegWr, exMemtoReg, exBrTaken, exJump,
      input  hazard, pcHold, ifidHold, ifidFlush, fwdA, fwdB, stallCnt, flushCnt
   );

   modport slave (
      input  idRa, idRb, exRa, exRb, exRw, exRegWr, exMemtoReg, exBrTaken, exJump,
      output hazard, pcHold, ifidHold, ifidFlush, fwdA, fwdB, stallCnt, flushCnt
   );

endinterface

// File: rtl/hazard_ctrl_fwd.sv
// Forwarding select for one EX operand, chosen from the MEM and WB destination trackers.
module fwd_unit
   import hazard_pkg::*;
(
   input  logic [4:0] exR_i,
   input  logic [4:0] memRw_i,
   input  logic       memRegWr_i,
   input  logic       memMemtoReg_i,
   input  logic [4:0] wbRw_i,
   input  logic       wbRegWr_i,
   output logic [1:0] sel_o
);

   // A load in MEM has no data yet, so only ALU results forward from MEM; MEM is newer than WB.
   always_comb begin
      sel_o = FWD_RF;
      if (regHit(memRw_i, memRegWr_i, exR_i) && !memMemtoReg_i) begin
         sel_o = FWD_MEM;
      end else if (regHit(wbRw_i, wbRegWr_i, exR_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, branch/jump flushes, EX forwarding selects and event counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave bus
);

   localparam int MAX_C = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
   localparam int REM_W = (MAX_C < 2) ? 1 : $clog2(MAX_C);

   state_t           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
   logic [4:0]       memRw_q, wbRw_q;
   logic             memRegWr_q, memMemtoReg_q, wbRegWr_q;

   logic loadUse, redirect;
   logic hazardC, pcHoldC, ifidHoldC, ifidFlushC;
   logic stallInc, flushInc;

   assign loadUse  = bus.exMemtoReg && bus.exRegWr && (bus.exRw != 5'd0) &&
                     ((bus.exRw == bus.idRa) || (bus.exRw == bus.idRb));
   assign redirect = bus.exBrTaken || bus.exJump;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         stallCnt_q    <= '0;
         flushCnt_q    <= '0;
         memRw_q       <= '0;
         memRegWr_q    <= 1'b0;
         memMemtoReg_q <= 1'b0;
         wbRw_q        <= '0;
         wbRegWr_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         stallCnt_q    <= stallCnt_d;
         flushCnt_q    <= flushCnt_d;
         memRw_q       <= bus.exRw;
         memRegWr_q    <= bus.exRegWr;
         memMemtoReg_q <= bus.exMemtoReg;
         wbRw_q        <= memRw_q;
         wbRegWr_q     <= memRegWr_q;
      end
   end

   // A redirect beats a load-use: the instruction in ID is on the wrong path and is being flushed.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      hazardC    = 1'b0;
      pcHoldC    = 1'b0;
      ifidHoldC  = 1'b0;
      ifidFlushC = 1'b0;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               hazardC    = 1'b1;
               ifidFlushC = 1'b1;
               flushInc   = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  rem_d   = REM_W'(FLUSH_CYCLES - 1);
               end
            end else if (loadUse) begin
               hazardC   = 1'b1;
               pcHoldC   = 1'b1;
               ifidHoldC = 1'b1;
               stallInc  = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_d = STALL;
                  rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
               end
            end
         end
         STALL: begin
            hazardC   = 1'b1;
            pcHoldC   = 1'b1;
            ifidHoldC = 1'b1;
            stallInc  = 1'b1;
            rem_d     = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = IDLE;
         end
         FLUSH: begin
            hazardC    = 1'b1;
            ifidFlushC = 1'b1;
            rem_d      = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Event counters stick at all-ones rather than wrapping.
   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (stallInc && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
      if (flushInc && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
   end

   assign bus.hazard    = rst_n && hazardC;
   assign bus.pcHold    = rst_n && pcHoldC;
   assign bus.ifidHold  = rst_n && ifidHoldC;
   assign bus.ifidFlush = rst_n && ifidFlushC;
   assign bus.stallCnt  = stallCnt_q;
   assign bus.flushCnt  = flushCnt_q;

   fwd_unit uFwdA (
      .exR_i         (bus.exRa),
      .memRw_i       (memRw_q),
      .memRegWr_i    (memRegWr_q),
      .memMemtoReg_i (memMemtoReg_q),
      .wbRw_i        (wbRw_q),
      .wbRegWr_i     (wbRegWr_q),
      .sel_o         (bus.fwdA)
   );

   fwd_unit uFwdB (
      .exR_i         (bus.exRb),
      .memRw_i       (memRw_q),
      .memRegWr_i    (memRegWr_q),
      .memMemtoReg_i (memMemtoReg_q),
      .wbRw_i        (wbRw_q),
      .wbRegWr_i     (wbRegWr_q),
      .sel_o         (bus.fwdB)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: four configurations share one stimulus stream; a negedge monitor checks.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [28:0] inVec = '0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int    cyc;
      int    dut;
      int    sig;
      int    exp;
      string name;
   } chk_t;

   chk_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // d0 default, d1 three-cycle load stall, d2 two-cycle flush, d3 two-bit counters
   hazard_ctrl_if #(.CNT_W(16)) ifc0 ();
   hazard_ctrl_if #(.CNT_W(16)) ifc1 ();
   hazard_ctrl_if #(.CNT_W(16)) ifc2 ();
   hazard_ctrl_if #(.CNT_W(2))  ifc3 ();

   assign {ifc0.idRa, ifc0.idRb, ifc0.exRa, ifc0.exRb, ifc0.exRw,
           ifc0.exRegWr, ifc0.exMemtoReg, ifc0.exBrTaken, ifc0.exJump} = inVec;
   assign {ifc1.idRa, ifc1.idRb, ifc1.exRa, ifc1.exRb, ifc1.exRw,
           ifc1.exRegWr, ifc1.exMemtoReg, ifc1.exBrTaken, ifc1.exJump} = inVec;
   assign {ifc2.idRa, ifc2.idRb, ifc2.exRa, ifc2.exRb, ifc2.exRw,
           ifc2.exRegWr, ifc2.exMemtoReg, ifc2.exBrTaken, ifc2.exJump} = inVec;
   assign {ifc3.idRa, ifc3.idRb, ifc3.exRa, ifc3.exRb, ifc3.exRw,
           ifc3.exRegWr, ifc3.exMemtoReg, ifc3.exBrTaken, ifc3.exJump} = inVec;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));
   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2))  u3 (.clk(clk), .rst_n(rst_n), .bus(ifc3.slave));

   function automatic int sel8(input int sig, input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7);
      case (sig)
         0: return a0;
         1: return a1;
         2: return a2;
         3: return a3;
         4: return a4;
         5: return a5;
         6: return a6;
         default: return a7;
      endcase
   endfunction

   function automatic int getSig(input int dut, input int sig);
      case (dut)
         0: return sel8(sig, int'(ifc0.hazard), int'(ifc0.pcHold), int'(ifc0.ifidHold), int'(ifc0.ifidFlush),
                        int'(ifc0.fwdA), int'(ifc0.fwdB), int'(ifc0.stallCnt), int'(ifc0.flushCnt));
         1: return sel8(sig, int'(ifc1.hazard), int'(ifc1.pcHold), int'(ifc1.ifidHold), int'(ifc1.ifidFlush),
                        int'(ifc1.fwdA), int'(ifc1.fwdB), int'(ifc1.stallCnt), int'(ifc1.flushCnt));
         2: return sel8(sig, int'(ifc2.hazard), int'(ifc2.pcHold), int'(ifc2.ifidHold), int'(ifc2.ifidFlush),
                        int'(ifc2.fwdA), int'(ifc2.fwdB), int'(ifc2.stallCnt), int'(ifc2.flushCnt));
         default: return sel8(sig, int'(ifc3.hazard), int'(ifc3.pcHold), int'(ifc3.ifidHold), int'(ifc3.ifidFlush),
                        int'(ifc3.fwdA), int'(ifc3.fwdB), int'(ifc3.stallCnt), int'(ifc3.flushCnt));
      endcase
   endfunction

   task automatic checkOutput(input chk_t c);
      int actual;
      actual = getSig(c.dut, c.sig);
      total++;
      if (actual != c.exp) begin
         bad++;
         $display("[TB] FAIL %s dut%0d cyc%0d: got %0d expected %0d", c.name, c.dut, c.cyc, actual, c.exp);
      end
   endtask

   // Monitor: retire every expectation tagged for the current cycle, mid-cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         checkOutput(sb.pop_front());
      end
   end

   task automatic pushExp(input int dut, input int sig, input int exp, input string name);
      chk_t c;
      c.cyc  = cyc;
      c.dut  = dut;
      c.sig  = sig;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic expectCtl(input int dut, input string tag, input int h, input int p, input int i, input int f);
      pushExp(dut, 0, h, {tag, ".hazard"});
      pushExp(dut, 1, p, {tag, ".pc_hold"});
      pushExp(dut, 2, i, {tag, ".ifid_hold"});
      pushExp(dut, 3, f, {tag, ".ifid_flush"});
   endtask

   task automatic expectCnt(input int dut, input string tag, input int s, input int f);
      pushExp(dut, 6, s, {tag, ".stall_cnt"});
      pushExp(dut, 7, f, {tag, ".flush_cnt"});
   endtask

   task automatic expectFwd(input int dut, input string tag, input int a, input int b);
      pushExp(dut, 4, a, {tag, ".fwd_A"});
      pushExp(dut, 5, b, {tag, ".fwd_B"});
   endtask

   task automatic applyStimulus(input logic [4:0] ida, input logic [4:0] idb, input logic [4:0] exa,
                                input logic [4:0] exb, input logic [4:0] exw, input logic regWr,
                                input logic memtoReg, input logic brTaken, input logic jump);
      @(posedge clk);
      #1;
      inVec = {ida, idb, exa, exb, exw, regWr, memtoReg, brTaken, jump};
   endtask

   task automatic loadUse();
      applyStimulus(5, 0, 0, 0, 5, 1, 1, 0, 0);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jump();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      inVec = {5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0};

      // Outputs held low under reset even with a load-use pattern present
      loadUse();
      for (int d = 0; d < 4; d++) begin
         expectCtl(d, "rst", 0, 0, 0, 0);
         expectCnt(d, "rst", 0, 0);
      end
      expectFwd(0, "rst", 0, 0);
      idle();
      rst_n = 1'b1;

      // Load-use: one bubble by default, three with LOAD_STALL_CYCLES=3
      loadUse();
      for (int d = 0; d < 4; d++) expectCtl(d, "lu", 1, 1, 1, 0);
      expectCnt(0, "lu", 0, 0);
      idle();
      expectCtl(0, "lu_done", 0, 0, 0, 0);
      expectCnt(0, "lu_done", 1, 0);
      expectCtl(1, "lu3_c2", 1, 1, 1, 0);
      expectCnt(1, "lu3_c2", 1, 0);
      idle();
      expectCtl(1, "lu3_c3", 1, 1, 1, 0);
      expectCnt(1, "lu3_c3", 2, 0);
      idle();
      expectCtl(1, "lu3_done", 0, 0, 0, 0);
      expectCnt(1, "lu3_done", 3, 0);

      // Branch taken together with load-use: flush wins, no stall counted
      applyStimulus(5, 0, 0, 0, 5, 1, 1, 1, 0);
      for (int d = 0; d < 4; d++) expectCtl(d, "br_lu", 1, 0, 0, 1);
      expectCnt(0, "br_lu", 1, 0);
      idle();
      expectCtl(0, "br_done", 0, 0, 0, 0);
      expectCnt(0, "br_done", 1, 1);
      expectCtl(2, "fl2_c2", 1, 0, 0, 1);
      expectCnt(2, "fl2_c2", 1, 1);
      idle();
      expectCtl(2, "fl2_done", 0, 0, 0, 0);

      // Forwarding: MEM, WB, MEM-over-WB, loads not from MEM, r0 never forwarded
      applyStimulus(0, 0, 0, 0, 3, 1, 0, 0, 0);
      expectFwd(0, "fwd_none", 0, 0);
      applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0);
      expectFwd(0, "fwd_mem", 1, 0);
      applyStimulus(0, 0, 3, 3, 3, 1, 0, 0, 0);
      expectFwd(0, "fwd_wb", 2, 2);
      applyStimulus(0, 0, 3, 0, 3, 1, 0, 0, 0);
      expectFwd(0, "fwd_mem2", 1, 0);
      applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0);
      expectFwd(0, "fwd_mem_over_wb", 1, 0);
      applyStimulus(0, 0, 0, 0, 4, 1, 1, 0, 0);
      expectCtl(0, "ld_no_use", 0, 0, 0, 0);
      applyStimulus(0, 0, 4, 4, 0, 0, 0, 0, 0);
      expectFwd(0, "fwd_ld_in_mem", 0, 0);
      applyStimulus(0, 0, 4, 0, 0, 0, 0, 0, 0);
      expectFwd(0, "fwd_ld_in_wb", 2, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
      expectCtl(0, "r0_no_stall", 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle();
      expectFwd(0, "fwd_r0", 0, 0);

      // Redirect during FLUSH is ignored; in IDLE each redirect counts
      jump();
      expectCtl(0, "j1", 1, 0, 0, 1);
      expectCtl(2, "j1", 1, 0, 0, 1);
      jump();
      expectCtl(0, "j2", 1, 0, 0, 1);
      expectCnt(0, "j2", 1, 2);
      expectCtl(2, "j2", 1, 0, 0, 1);
      expectCnt(2, "j2", 1, 2);
      idle();
      expectCtl(2, "j_done", 0, 0, 0, 0);
      expectCnt(2, "j_done", 1, 2);
      expectCnt(0, "j_done", 1, 3);
      expectCnt(3, "j_sat", 1, 3);

      // Five more stall events: two-bit counter saturates at 3
      for (int k = 0; k < 5; k++) begin
         loadUse();
         idle();
         if (k == 1) expectCnt(3, "sat_early", 3, 3);
      end
      expectCnt(3, "sat_stall", 3, 3);
      expectCnt(0, "nosat_stall", 6, 3);
      idle();
      idle();
      jump();
      idle();
      expectCnt(0, "flush4", 6, 4);
      expectCnt(3, "sat_flush", 3, 3);

      // Reset asserted while the three-cycle stall has two cycles left
      loadUse();
      expectCtl(1, "pre_rst", 1, 1, 1, 0);
      idle();
      rst_n = 1'b0;
      expectCtl(1, "mid_rst", 0, 0, 0, 0);
      expectCnt(1, "mid_rst", 0, 0);
      expectCnt(0, "mid_rst", 0, 0);
      idle();
      rst_n = 1'b1;
      expectCtl(1, "post_rst", 0, 0, 0, 0);
      expectCnt(1, "post_rst", 0, 0);
      loadUse();
      expectCtl(1, "post_rst_lu", 1, 1, 1, 0);
      expectCnt(1, "post_rst_lu", 0, 0);
      idle();
      expectCtl(1, "post_rst_stall", 1, 1, 1, 0);
      expectCnt(1, "post_rst_stall", 1, 0);
      idle();
      idle();

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
